// File: rtl/cache_line_mover.sv
// cache_line_mover: writes back a dirty victim line, then fills the missing line word by word through MainMemory
module cache_line_mover #(
  parameter int WORD_IDX_BITS = 2,
  parameter int ADDR_BITS     = 30
) (
  input  logic                                CLK,
  input  logic                                RST_N,
  input  logic                                REQ,
  input  logic                                REQ_DIRTY,
  input  logic [ADDR_BITS-WORD_IDX_BITS-1:0]  WB_LINE_ADDR,
  input  logic [ADDR_BITS-WORD_IDX_BITS-1:0]  FILL_LINE_ADDR,
  output logic [WORD_IDX_BITS-1:0]            WB_WORD_IDX,
  input  logic [31:0]                         WB_DATA,
  output logic                                FILL_WE,
  output logic [WORD_IDX_BITS-1:0]            FILL_WORD_IDX,
  output logic [31:0]                         FILL_DATA,
  output logic                                BUSY,
  output logic                                DONE,
  output logic                                MEM_RE,
  output logic                                MEM_WE,
  output logic [ADDR_BITS-1:0]                MEM_ADDR,
  output logic [31:0]                         MEM_DATA_IN,
  input  logic [31:0]                         MEM_DOUT,
  input  logic                                MEM_VALID
);
  localparam int LB = ADDR_BITS - WORD_IDX_BITS;
  localparam logic [WORD_IDX_BITS-1:0] W0 = '0;
  localparam logic [WORD_IDX_BITS-1:0] W1 = WORD_IDX_BITS'(1);
  typedef enum logic [2:0] {S_IDLE, S_WB_ACC, S_WB_GAP, S_FILL_ACC, S_FILL_GAP, S_DONE} state_t;
  state_t state_q, state_d;
  logic [WORD_IDX_BITS-1:0] cnt_q, cnt_d, cnt_inc, wb_idx_q, wb_idx_d, fill_idx_q, fill_idx_d;
  logic [LB-1:0] wb_line_q, wb_line_d, fill_line_q, fill_line_d;
  logic [ADDR_BITS-1:0] mem_addr_q, mem_addr_d;
  logic [31:0] mem_data_q, mem_data_d, fill_data_q, fill_data_d;
  logic mem_re_q, mem_re_d, mem_we_q, mem_we_d, fill_we_q, fill_we_d, busy_q, busy_d, done_q, done_d;
  logic last;
  assign cnt_inc = cnt_q + W1;
  assign last = &cnt_q;
  assign WB_WORD_IDX = wb_idx_q;
  assign FILL_WE = fill_we_q;
  assign FILL_WORD_IDX = fill_idx_q;
  assign FILL_DATA = fill_data_q;
  assign BUSY = busy_q;
  assign DONE = done_q;
  assign MEM_RE = mem_re_q;
  assign MEM_WE = mem_we_q;
  assign MEM_ADDR = mem_addr_q;
  assign MEM_DATA_IN = mem_data_q;
  // next-state and next-output logic; every output is computed here and registered below
  always_comb begin
    state_d = state_q;
    cnt_d = cnt_q;
    wb_line_d = wb_line_q;
    fill_line_d = fill_line_q;
    mem_re_d = mem_re_q;
    mem_we_d = mem_we_q;
    mem_addr_d = mem_addr_q;
    mem_data_d = mem_data_q;
    wb_idx_d = wb_idx_q;
    fill_we_d = 1'b0;
    fill_idx_d = fill_idx_q;
    fill_data_d = fill_data_q;
    busy_d = busy_q;
    done_d = 1'b0;
    case (state_q)
      S_IDLE: if (REQ) begin
        wb_line_d = WB_LINE_ADDR;
        fill_line_d = FILL_LINE_ADDR;
        cnt_d = W0;
        busy_d = 1'b1;
        state_d = REQ_DIRTY ? S_WB_ACC : S_FILL_ACC;
        mem_we_d = REQ_DIRTY;
        mem_re_d = !REQ_DIRTY;
        mem_addr_d = REQ_DIRTY ? {WB_LINE_ADDR, W0} : {FILL_LINE_ADDR, W0};
        mem_data_d = REQ_DIRTY ? WB_DATA : mem_data_q;
      end
      S_WB_ACC: if (MEM_VALID) begin
        state_d = S_WB_GAP;
        mem_we_d = 1'b0;
        wb_idx_d = cnt_inc;
      end
      S_WB_GAP: begin
        cnt_d = cnt_inc;
        state_d = last ? S_FILL_ACC : S_WB_ACC;
        mem_we_d = !last;
        mem_re_d = last;
        mem_addr_d = last ? {fill_line_q, W0} : {wb_line_q, cnt_inc};
        mem_data_d = last ? mem_data_q : WB_DATA;
      end
      S_FILL_ACC: if (MEM_VALID) begin
        state_d = S_FILL_GAP;
        mem_re_d = 1'b0;
        fill_we_d = 1'b1;
        fill_idx_d = cnt_q;
        fill_data_d = MEM_DOUT;
      end
      S_FILL_GAP: begin
        cnt_d = last ? cnt_q : cnt_inc;
        state_d = last ? S_DONE : S_FILL_ACC;
        mem_re_d = !last;
        mem_addr_d = last ? mem_addr_q : {fill_line_q, cnt_inc};
        done_d = last;
        busy_d = !last;
      end
      S_DONE: state_d = S_IDLE;
      default: state_d = S_IDLE;
    endcase
  end
  // state and output registers; async reset drops every output to zero at once
  always_ff @(posedge CLK or negedge RST_N) begin
    if (!RST_N) begin
      state_q <= S_IDLE;
      cnt_q <= '0;
      wb_line_q <= '0;
      fill_line_q <= '0;
      mem_re_q <= 1'b0;
      mem_we_q <= 1'b0;
      mem_addr_q <= '0;
      mem_data_q <= '0;
      wb_idx_q <= '0;
      fill_we_q <= 1'b0;
      fill_idx_q <= '0;
      fill_data_q <= '0;
      busy_q <= 1'b0;
      done_q <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q <= cnt_d;
      wb_line_q <= wb_line_d;
      fill_line_q <= fill_line_d;
      mem_re_q <= mem_re_d;
      mem_we_q <= mem_we_d;
      mem_addr_q <= mem_addr_d;
      mem_data_q <= mem_data_d;
      wb_idx_q <= wb_idx_d;
      fill_we_q <= fill_we_d;
      fill_idx_q <= fill_idx_d;
      fill_data_q <= fill_data_d;
      busy_q <= busy_d;
      done_q <= done_d;
    end
  end
endmodule

// File: tb/tb_cache_line_mover.sv
// tb_cache_line_mover: randomized and directed line transfers against a MainMemory model and a line-level reference
module tb_cache_line_mover;
  localparam int W = 2;
  localparam int A = 30;
  localparam int L = A - W;
  logic CLK = 1'b0;
  logic RST_N = 1'b0;
  logic REQ = 1'b0;
  logic REQ_DIRTY = 1'b0;
  logic [L-1:0] WB_LINE_ADDR = '0;
  logic [L-1:0] FILL_LINE_ADDR = '0;
  logic [W-1:0] WB_WORD_IDX, FILL_WORD_IDX;
  logic [31:0] WB_DATA, FILL_DATA, MEM_DATA_IN, MEM_DOUT;
  logic FILL_WE, BUSY, DONE, MEM_RE, MEM_WE, MEM_VALID, mv_real;
  logic force_v = 1'b0;
  logic [A-1:0] MEM_ADDR;
  logic [31:0] mem [256];
  logic [31:0] ref_mem [256];
  logic [31:0] cache_w [4];
  logic [4:0] mcnt = '0;
  logic [102:0] outs, rst_snap;
  int n_vec = 0;
  int n_err = 0;
  int k, done_at, n_done, both_hi, outside, gap_bad, addr_bad, busy_bad, last_wr_k, first_rd_k, low_run;
  bit had_acc;
  logic [A-1:0] last_addr;
  logic [A-1:0] wr_a[$];
  logic [31:0] wr_d[$];
  logic [A-1:0] rd_a[$];
  logic [W-1:0] fi[$];
  logic [31:0] fd[$];
  logic [A-1:0] ex_wa[$];
  logic [31:0] ex_wd[$];
  logic [31:0] ex_fd[$];
  int ex_done;

  cache_line_mover #(.WORD_IDX_BITS(W), .ADDR_BITS(A)) dut (
    .CLK(CLK), .RST_N(RST_N), .REQ(REQ), .REQ_DIRTY(REQ_DIRTY),
    .WB_LINE_ADDR(WB_LINE_ADDR), .FILL_LINE_ADDR(FILL_LINE_ADDR),
    .WB_WORD_IDX(WB_WORD_IDX), .WB_DATA(WB_DATA),
    .FILL_WE(FILL_WE), .FILL_WORD_IDX(FILL_WORD_IDX), .FILL_DATA(FILL_DATA),
    .BUSY(BUSY), .DONE(DONE), .MEM_RE(MEM_RE), .MEM_WE(MEM_WE),
    .MEM_ADDR(MEM_ADDR), .MEM_DATA_IN(MEM_DATA_IN), .MEM_DOUT(MEM_DOUT), .MEM_VALID(MEM_VALID)
  );

  always #5 CLK = ~CLK;
  // MainMemory: valid after 16 consecutive enabled cycles, idle data reads as DEADBEEF
  always @(posedge CLK) mcnt <= (MEM_RE || MEM_WE) ? mcnt + 5'd1 : 5'd0;
  assign mv_real = (MEM_RE || MEM_WE) && mcnt == 5'd15;
  assign MEM_VALID = mv_real || force_v;
  assign MEM_DOUT = (MEM_RE && MEM_VALID) ? mem[MEM_ADDR[7:0]] : 32'hDEADBEEF;
  assign WB_DATA = cache_w[WB_WORD_IDX];
  assign outs = {WB_WORD_IDX, FILL_WE, FILL_WORD_IDX, FILL_DATA, BUSY, DONE, MEM_RE, MEM_WE, MEM_ADDR, MEM_DATA_IN};

  task automatic preload();
    logic [31:0] v;
    for (int i = 0; i < 256; i++) begin
      v = $urandom;
      if (v == 32'hDEADBEEF) v = 32'h0;
      mem[i] = v;
      ref_mem[i] = v;
    end
    for (int i = 0; i < 4; i++) cache_w[i] = $urandom;
  endtask

  task automatic set_word(input int a, input logic [31:0] v);
    mem[a] = v;
    ref_mem[a] = v;
  endtask

  // line-level reference: victim words go to memory first, then the fill line is read back
  task automatic model(input bit dirty, input logic [L-1:0] wb, input logic [L-1:0] fill);
    ex_wa.delete();
    ex_wd.delete();
    ex_fd.delete();
    if (dirty) for (int i = 0; i < 4; i++) begin
      ex_wa.push_back(A'(int'(wb) * 4 + i));
      ex_wd.push_back(cache_w[i]);
      ref_mem[8'(int'(wb) * 4 + i)] = cache_w[i];
    end
    for (int i = 0; i < 4; i++) ex_fd.push_back(ref_mem[8'(int'(fill) * 4 + i)]);
    ex_done = 1 + (dirty ? 8 : 4) * 17 + 1;
  endtask

  task automatic kick(input bit dirty, input logic [L-1:0] wb, input logic [L-1:0] fill);
    @(negedge CLK);
    REQ = 1'b1;
    REQ_DIRTY = dirty;
    WB_LINE_ADDR = wb;
    FILL_LINE_ADDR = fill;
  endtask

  // runs one transfer to DONE (bounded by limit) and records what the DUT did, cycle 1 being the REQ cycle
  task automatic observe(input int limit, input int tail, input bit hold, input int rst_k, input bit glitch);
    int after;
    bit seen;
    after = 0; seen = 0; k = 1; done_at = -1; n_done = 0;
    both_hi = 0; outside = 0; gap_bad = 0; addr_bad = 0; busy_bad = 0;
    last_wr_k = -1; first_rd_k = -1; low_run = 0; had_acc = 0; rst_snap = '1; last_addr = '0;
    wr_a.delete(); wr_d.delete(); rd_a.delete(); fi.delete(); fd.delete();
    while (k < limit && !(seen && after >= tail)) begin
      @(negedge CLK);
      k++;
      if (!hold || seen) REQ = 1'b0;
      if (k == rst_k + 1) RST_N = 1'b1;
      if (k == rst_k) begin
        RST_N = 1'b0;
        #1;
        rst_snap = outs;
      end
      if (MEM_RE && MEM_WE) both_hi++;
      if ((MEM_RE || MEM_WE) && !BUSY) outside++;
      if (MEM_RE || MEM_WE) begin
        if (low_run > 1) gap_bad++;
        if (had_acc && low_run == 0 && MEM_ADDR !== last_addr) addr_bad++;
        had_acc = 1;
        low_run = 0;
        last_addr = MEM_ADDR;
      end else if (had_acc && BUSY) low_run++;
      if (mv_real && MEM_WE) begin
        mem[MEM_ADDR[7:0]] = MEM_DATA_IN;
        wr_a.push_back(MEM_ADDR);
        wr_d.push_back(MEM_DATA_IN);
        last_wr_k = k;
      end
      if (mv_real && MEM_RE) begin
        rd_a.push_back(MEM_ADDR);
        if (first_rd_k < 0) first_rd_k = k;
      end
      if (FILL_WE) begin
        fi.push_back(FILL_WORD_IDX);
        fd.push_back(FILL_DATA);
      end
      if (rst_k < 0 && ((!seen && !DONE && !BUSY) || (seen && BUSY))) busy_bad++;
      if (DONE) begin
        n_done++;
        if (!seen) done_at = k;
        seen = 1;
      end else if (seen) after++;
      force_v = glitch && BUSY && !MEM_RE && !MEM_WE && had_acc;
    end
    force_v = 1'b0;
    REQ = 1'b0;
    RST_N = 1'b1;
  endtask

  task automatic test_reset();
    RST_N = 1'b0;
    #2;
    n_vec++;
    if (outs !== '0) begin n_err++; $display("FAIL reset_outputs: got %h want 0", outs); end
    @(negedge CLK);
    RST_N = 1'b1;
    repeat (3) @(negedge CLK);
    n_vec++;
    if (outs !== '0) begin n_err++; $display("FAIL idle_outputs: got %h want 0", outs); end
  endtask

  task automatic test_clean_fill();
    preload();
    for (int i = 0; i < 4; i++) set_word(8'h40 + i, 32'hA0 + i);
    model(1'b0, 28'h05, 28'h10);
    kick(1'b0, 28'h05, 28'h10);
    observe(100, 3, 1'b0, -1, 1'b0);
    n_vec++;
    if (done_at !== 70) begin n_err++; $display("FAIL clean_done_cycle: got %0d want 70", done_at); end
    n_vec++;
    if (n_done !== 1) begin n_err++; $display("FAIL clean_done_count: got %0d want 1", n_done); end
    n_vec++;
    if (wr_a.size() !== 0 || both_hi !== 0) begin n_err++; $display("FAIL clean_no_write: got %0d writes %0d overlaps want 0", wr_a.size(), both_hi); end
    n_vec++;
    if (rd_a.size() !== 4) begin n_err++; $display("FAIL clean_read_count: got %0d want 4", rd_a.size()); end
    for (int i = 0; i < rd_a.size(); i++) begin
      n_vec++;
      if (rd_a[i] !== A'(32'h40 + i)) begin n_err++; $display("FAIL clean_read_addr%0d: got %h want %h", i, rd_a[i], 32'h40 + i); end
    end
    n_vec++;
    if (fi.size() !== 4) begin n_err++; $display("FAIL clean_fill_count: got %0d want 4", fi.size()); end
    for (int i = 0; i < fi.size(); i++) begin
      n_vec++;
      if (fi[i] !== W'(i) || fd[i] !== 32'hA0 + i) begin n_err++; $display("FAIL clean_fill%0d: got idx %0d data %h want idx %0d data %h", i, fi[i], fd[i], i, 32'hA0 + i); end
    end
    n_vec++;
    if (gap_bad + addr_bad + outside + busy_bad !== 0) begin n_err++; $display("FAIL clean_hygiene: got gap %0d addr %0d outside %0d busy %0d want 0", gap_bad, addr_bad, outside, busy_bad); end
  endtask

  task automatic test_dirty_miss();
    preload();
    for (int i = 0; i < 4; i++) cache_w[i] = 32'h11 + i;
    model(1'b1, 28'h20, 28'h30);
    kick(1'b1, 28'h20, 28'h30);
    observe(200, 3, 1'b0, -1, 1'b0);
    n_vec++;
    if (done_at !== 138) begin n_err++; $display("FAIL dirty_done_cycle: got %0d want 138", done_at); end
    n_vec++;
    if (wr_a.size() !== 4) begin n_err++; $display("FAIL dirty_write_count: got %0d want 4", wr_a.size()); end
    for (int i = 0; i < wr_a.size(); i++) begin
      n_vec++;
      if (wr_a[i] !== A'(32'h80 + i) || wr_d[i] !== 32'h11 + i) begin n_err++; $display("FAIL dirty_write%0d: got %h=%h want %h=%h", i, wr_a[i], wr_d[i], 32'h80 + i, 32'h11 + i); end
    end
    n_vec++;
    if (!(last_wr_k >= 0 && first_rd_k > last_wr_k)) begin n_err++; $display("FAIL dirty_order: got last write %0d first read %0d want write first", last_wr_k, first_rd_k); end
    n_vec++;
    if (rd_a.size() !== 4) begin n_err++; $display("FAIL dirty_read_count: got %0d want 4", rd_a.size()); end
    for (int i = 0; i < rd_a.size(); i++) begin
      n_vec++;
      if (rd_a[i] !== A'(32'hC0 + i)) begin n_err++; $display("FAIL dirty_read_addr%0d: got %h want %h", i, rd_a[i], 32'hC0 + i); end
    end
    for (int i = 0; i < fd.size(); i++) begin
      n_vec++;
      if (fi[i] !== W'(i) || fd[i] !== ex_fd[i]) begin n_err++; $display("FAIL dirty_fill%0d: got idx %0d data %h want idx %0d data %h", i, fi[i], fd[i], i, ex_fd[i]); end
    end
    n_vec++;
    if (fd.size() !== 4 || both_hi + gap_bad + addr_bad + outside + busy_bad !== 0) begin n_err++; $display("FAIL dirty_hygiene: got fills %0d overlap %0d gap %0d addr %0d outside %0d busy %0d want 4/0", fd.size(), both_hi, gap_bad, addr_bad, outside, busy_bad); end
  endtask

  task automatic test_req_held();
    preload();
    kick(1'b0, L'($urandom_range(63)), L'($urandom_range(63)));
    observe(120, 30, 1'b1, -1, 1'b0);
    n_vec++;
    if (n_done !== 1 || done_at !== 70) begin n_err++; $display("FAIL held_single_transfer: got %0d dones at %0d want 1 at 70", n_done, done_at); end
    n_vec++;
    if (rd_a.size() !== 4 || outside !== 0) begin n_err++; $display("FAIL held_reads: got %0d reads %0d outside want 4/0", rd_a.size(), outside); end
    n_vec++;
    if (busy_bad !== 0) begin n_err++; $display("FAIL held_busy: got %0d bad cycles want 0", busy_bad); end
  endtask

  task automatic test_reset_mid();
    preload();
    kick(1'b0, 28'h07, 28'h10);
    observe(80, 0, 1'b0, 40, 1'b0);
    n_vec++;
    if (rst_snap !== '0) begin n_err++; $display("FAIL midreset_outputs: got %h want 0", rst_snap); end
    n_vec++;
    if (n_done !== 0 || fi.size() !== 2) begin n_err++; $display("FAIL midreset_aborted: got %0d dones %0d fills want 0/2", n_done, fi.size()); end
    n_vec++;
    if (BUSY !== 1'b0 || outside !== 0) begin n_err++; $display("FAIL midreset_idle: got busy %b outside %0d want 0/0", BUSY, outside); end
    preload();
    model(1'b0, 28'h07, 28'h10);
    kick(1'b0, 28'h07, 28'h10);
    observe(100, 3, 1'b0, -1, 1'b0);
    n_vec++;
    if (done_at !== 70) begin n_err++; $display("FAIL midreset_refill_cycle: got %0d want 70", done_at); end
    for (int i = 0; i < fd.size(); i++) begin
      n_vec++;
      if (fd[i] !== ex_fd[i]) begin n_err++; $display("FAIL midreset_fill%0d: got %h want %h", i, fd[i], ex_fd[i]); end
    end
  endtask

  task automatic test_valid_glitch();
    int bad;
    bad = 0;
    @(negedge CLK);
    force_v = 1'b1;
    for (int i = 0; i < 4; i++) begin
      @(negedge CLK);
      if (FILL_WE || BUSY || MEM_RE || MEM_WE || DONE) bad++;
    end
    force_v = 1'b0;
    n_vec++;
    if (bad !== 0) begin n_err++; $display("FAIL glitch_idle: got %0d active cycles want 0", bad); end
    preload();
    model(1'b0, 28'h01, L'($urandom_range(63)));
    kick(1'b0, 28'h01, FILL_LINE_ADDR);
    FILL_LINE_ADDR = L'(int'(ex_wa.size()) + 0) | FILL_LINE_ADDR;
    observe(100, 3, 1'b0, -1, 1'b1);
    n_vec++;
    if (done_at !== 70 || fd.size() !== 4) begin n_err++; $display("FAIL glitch_gap_timing: got done %0d fills %0d want 70/4", done_at, fd.size()); end
    for (int i = 0; i < fd.size(); i++) begin
      n_vec++;
      if (fd[i] === 32'hDEADBEEF || fi[i] !== W'(i)) begin n_err++; $display("FAIL glitch_fill%0d: got idx %0d data %h want idx %0d real data", i, fi[i], fd[i], i); end
    end
  endtask

  task automatic test_random();
    bit dirty;
    logic [L-1:0] wb, fill;
    for (int t = 0; t < 8; t++) begin
      dirty = 1'($urandom);
      wb = L'($urandom_range(63));
      fill = (t == 3) ? wb : L'($urandom_range(63));
      for (int i = 0; i < 4; i++) cache_w[i] = $urandom;
      model(dirty, wb, fill);
      kick(dirty, wb, fill);
      observe(200, 2, 1'b0, -1, 1'b0);
      n_vec++;
      if (done_at !== ex_done) begin n_err++; $display("FAIL rand%0d_done_cycle: got %0d want %0d", t, done_at, ex_done); end
      n_vec++;
      if (wr_a.size() !== ex_wa.size() || rd_a.size() !== 4 || fd.size() !== 4) begin n_err++; $display("FAIL rand%0d_counts: got w%0d r%0d f%0d want w%0d r4 f4", t, wr_a.size(), rd_a.size(), fd.size(), ex_wa.size()); end
      for (int i = 0; i < wr_a.size() && i < ex_wa.size(); i++) begin
        n_vec++;
        if (wr_a[i] !== ex_wa[i] || wr_d[i] !== ex_wd[i]) begin n_err++; $display("FAIL rand%0d_write%0d: got %h=%h want %h=%h", t, i, wr_a[i], wr_d[i], ex_wa[i], ex_wd[i]); end
      end
      for (int i = 0; i < rd_a.size(); i++) begin
        n_vec++;
        if (rd_a[i] !== A'(int'(fill) * 4 + i)) begin n_err++; $display("FAIL rand%0d_read%0d: got %h want %h", t, i, rd_a[i], int'(fill) * 4 + i); end
      end
      for (int i = 0; i < fd.size(); i++) begin
        n_vec++;
        if (fi[i] !== W'(i) || fd[i] !== ex_fd[i]) begin n_err++; $display("FAIL rand%0d_fill%0d: got idx %0d data %h want idx %0d data %h", t, i, fi[i], fd[i], i, ex_fd[i]); end
      end
      n_vec++;
      if (both_hi + gap_bad + addr_bad + outside + busy_bad !== 0) begin n_err++; $display("FAIL rand%0d_hygiene: got overlap %0d gap %0d addr %0d outside %0d busy %0d want 0", t, both_hi, gap_bad, addr_bad, outside, busy_bad); end
    end
  endtask

  initial begin
    preload();
    test_reset();
    test_clean_fill();
    test_dirty_miss();
    test_req_held();
    test_reset_mid();
    test_valid_glitch();
    test_random();
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end
endmodule
